// File: rtl/lc3_pkg.sv
// Shared types and sizes for the register-file write scheduler.
// Holds data width, register count, register index type and arbiter state.
package lc3_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_W  = $clog2(NREG);

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } last_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Issue sets, write-back grant clears; a same-cycle set wins.
module regfile_scoreboard
#(
    parameter int NREG = lc3_pkg::NREG
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    input  logic [$clog2(NREG)-1:0] chk_rs1,
    input  logic [$clog2(NREG)-1:0] chk_rs2,
    input  logic                    clr_en,
    input  logic [$clog2(NREG)-1:0] clr_rd,
    output logic                    iss_ready,
    output logic                    hazard
);

    import lc3_pkg::*;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Readiness and hazard look at the bits before this cycle's set/clear.
    always_comb begin
        iss_ready = !pend_q[iss_rd] || (clr_en && (clr_rd == iss_rd));
        hazard    = pend_q[chk_rs1] | pend_q[chk_rs2];
    end

    // Next pending mask: clear the granted register, then apply the issue.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_rd] = 1'b0;
        end
        if (iss_valid && iss_ready) begin
            pend_d[iss_rd] = 1'b1;
        end
    end

    // Pending mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU and load write-backs onto one register-file write port.
// Define RR_ARB_EN for round-robin; otherwise MEM has fixed priority.
module regfile_write_scheduler
#(
    parameter int DATA_W = lc3_pkg::DATA_W,
    parameter int NREG   = lc3_pkg::NREG
)
(
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    ALU_REQ,
    input  logic [$clog2(NREG)-1:0] ALU_RD,
    input  logic [DATA_W-1:0]       ALU_DATA,
    output logic                    ALU_GNT,
    input  logic                    MEM_REQ,
    input  logic [$clog2(NREG)-1:0] MEM_RD,
    input  logic [DATA_W-1:0]       MEM_DATA,
    output logic                    MEM_GNT,
    input  logic                    ISS_VALID,
    input  logic [$clog2(NREG)-1:0] ISS_RD,
    output logic                    ISS_READY,
    input  logic [$clog2(NREG)-1:0] CHK_RS1,
    input  logic [$clog2(NREG)-1:0] CHK_RS2,
    output logic                    HAZARD,
    output logic                    RD_LE,
    output logic [$clog2(NREG)-1:0] RD,
    output logic [DATA_W-1:0]       DATA_IN
);

    import lc3_pkg::*;

    localparam int RW = $clog2(NREG);

    logic              alu_gnt;
    logic              mem_gnt;
    logic              any_gnt;
    logic [RW-1:0]     win_rd;
    logic [DATA_W-1:0] win_data;

    logic              rd_le_q;
    logic              rd_le_d;
    logic [RW-1:0]     rd_q;
    logic [RW-1:0]     rd_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

`ifdef RR_ARB_EN
    last_e last_q;
    last_e last_d;

    // Round-robin grant: on contention the side not served last wins.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        last_d  = last_q;
        if (RST_N) begin
            if (ALU_REQ && MEM_REQ) begin
                if (last_q == LAST_MEM) begin
                    alu_gnt = 1'b1;
                end else begin
                    mem_gnt = 1'b1;
                end
            end else if (ALU_REQ) begin
                alu_gnt = 1'b1;
            end else if (MEM_REQ) begin
                mem_gnt = 1'b1;
            end
            if (alu_gnt) begin
                last_d = LAST_ALU;
            end else if (mem_gnt) begin
                last_d = LAST_MEM;
            end
        end
    end

    // Last-winner register; reset favours the ALU first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q <= LAST_MEM;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed-priority grant: loads always beat the ALU.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (RST_N) begin
            if (MEM_REQ) begin
                mem_gnt = 1'b1;
            end else if (ALU_REQ) begin
                alu_gnt = 1'b1;
            end
        end
    end
`endif

    // Select the winning destination and value for the write port.
    always_comb begin
        any_gnt  = alu_gnt | mem_gnt;
        win_rd   = mem_gnt ? MEM_RD : ALU_RD;
        win_data = mem_gnt ? MEM_DATA : ALU_DATA;
        rd_le_d  = any_gnt;
        rd_d     = any_gnt ? win_rd : rd_q;
        data_d   = any_gnt ? win_data : data_q;
    end

    // Write port register: strobe for one cycle, address/data hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_le_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            rd_le_q <= rd_le_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk       (CLK),
        .rst_n     (RST_N),
        .iss_valid (ISS_VALID),
        .iss_rd    (ISS_RD),
        .chk_rs1   (CHK_RS1),
        .chk_rs2   (CHK_RS2),
        .clr_en    (any_gnt),
        .clr_rd    (win_rd),
        .iss_ready (ISS_READY),
        .hazard    (HAZARD)
    );

    assign ALU_GNT = alu_gnt;
    assign MEM_GNT = mem_gnt;
    assign RD_LE   = rd_le_q;
    assign RD      = rd_q;
    assign DATA_IN = data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: vector table plus
// hand sequences for arbitration order, same-RD ordering and reset.
module tb_regfile_write_scheduler;

    logic        clk;
    logic        rst_n;
    logic        alu_req;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_gnt;
    logic        mem_req;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_gnt;
    logic        iss_valid;
    logic [2:0]  iss_rd;
    logic        iss_ready;
    logic [2:0]  chk_rs1;
    logic [2:0]  chk_rs2;
    logic        hazard;
    logic        rd_le;
    logic [2:0]  rd;
    logic [15:0] data_in;

    int ntests;
    int nfail;

    regfile_write_scheduler dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .ALU_REQ   (alu_req),
        .ALU_RD    (alu_rd),
        .ALU_DATA  (alu_data),
        .ALU_GNT   (alu_gnt),
        .MEM_REQ   (mem_req),
        .MEM_RD    (mem_rd),
        .MEM_DATA  (mem_data),
        .MEM_GNT   (mem_gnt),
        .ISS_VALID (iss_valid),
        .ISS_RD    (iss_rd),
        .ISS_READY (iss_ready),
        .CHK_RS1   (chk_rs1),
        .CHK_RS2   (chk_rs2),
        .HAZARD    (hazard),
        .RD_LE     (rd_le),
        .RD        (rd),
        .DATA_IN   (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ar;
        logic [2:0]  ard;
        logic [15:0] ad;
        logic        mr;
        logic [2:0]  mrd;
        logic [15:0] md;
        logic        iv;
        logic [2:0]  ird;
        logic [2:0]  c1;
        logic [2:0]  c2;
        logic        ega;
        logic        egm;
        logic        erdy;
        logic        ehaz;
        logic        ele;
        logic [2:0]  erd;
        logic [15:0] edat;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic ar, input logic [2:0] ard, input logic [15:0] ad,
        input logic mr, input logic [2:0] mrd, input logic [15:0] md,
        input logic iv, input logic [2:0] ird,
        input logic [2:0] c1, input logic [2:0] c2,
        input logic ega, input logic egm, input logic erdy,
        input logic ehaz, input logic ele,
        input logic [2:0] erd, input logic [15:0] edat);
        vec_t v;
        v.ar = ar; v.ard = ard; v.ad = ad;
        v.mr = mr; v.mrd = mrd; v.md = md;
        v.iv = iv; v.ird = ird; v.c1 = c1; v.c2 = c2;
        v.ega = ega; v.egm = egm; v.erdy = erdy; v.ehaz = ehaz;
        v.ele = ele; v.erd = erd; v.edat = edat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_req = 0; alu_rd = 0; alu_data = 0;
        mem_req = 0; mem_rd = 0; mem_data = 0;
        iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic        exp_first_alu;
        logic [15:0] exp_final;
        logic        a_done;
        logic        m_done;
        logic        first_alu;
        logic        first_seen;
        int          guard;

        ntests = 0;
        nfail  = 0;
        idle_inputs();
        rst_n = 0;

        vecs[0]  = mk(1,3,16'h1234, 0,0,0, 0,0, 0,0,
                      1,0,1,0, 1,3,16'h1234);
        vecs[1]  = mk(0,0,0, 0,0,0, 0,0, 0,0,
                      0,0,1,0, 0,3,16'h1234);
        vecs[2]  = mk(0,0,0, 0,0,0, 1,5, 0,0,
                      0,0,1,0, 0,3,16'h1234);
        vecs[3]  = mk(0,0,0, 0,0,0, 1,5, 5,0,
                      0,0,0,1, 0,3,16'h1234);
        vecs[4]  = mk(0,0,0, 1,5,16'hBEEF, 0,0, 5,0,
                      0,1,1,1, 1,5,16'hBEEF);
        vecs[5]  = mk(0,0,0, 0,0,0, 0,0, 5,5,
                      0,0,1,0, 0,5,16'hBEEF);
        vecs[6]  = mk(0,0,0, 0,0,0, 1,2, 0,0,
                      0,0,1,0, 0,5,16'hBEEF);
        vecs[7]  = mk(1,2,16'h0022, 0,0,0, 1,2, 0,0,
                      1,0,1,0, 1,2,16'h0022);
        vecs[8]  = mk(0,0,0, 0,0,0, 1,2, 2,0,
                      0,0,0,1, 0,2,16'h0022);
        vecs[9]  = mk(1,7,16'h7777, 0,0,0, 0,0, 7,0,
                      1,0,1,0, 1,7,16'h7777);
        vecs[10] = mk(0,0,0, 0,0,0, 0,0, 7,7,
                      0,0,1,0, 0,7,16'h7777);
        vecs[11] = mk(0,0,0, 1,0,16'h0F0F, 0,0, 0,2,
                      0,1,1,1, 1,0,16'h0F0F);

        // reset state with a request pending
        @(negedge clk);
        alu_req = 1;
        #1;
        check("rst_alu_gnt", alu_gnt, 0);
        check("rst_rd_le", rd_le, 0);
        check("rst_rd", rd, 0);
        check("rst_data", data_in, 0);
        check("rst_hazard", hazard, 0);
        alu_req = 0;
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            alu_req = vecs[i].ar; alu_rd = vecs[i].ard;
            alu_data = vecs[i].ad;
            mem_req = vecs[i].mr; mem_rd = vecs[i].mrd;
            mem_data = vecs[i].md;
            iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
            chk_rs1 = vecs[i].c1; chk_rs2 = vecs[i].c2;
            #1;
            check($sformatf("v%0d_alu_gnt", i), alu_gnt, vecs[i].ega);
            check($sformatf("v%0d_mem_gnt", i), mem_gnt, vecs[i].egm);
            check($sformatf("v%0d_iss_ready", i), iss_ready, vecs[i].erdy);
            check($sformatf("v%0d_hazard", i), hazard, vecs[i].ehaz);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rd_le", i), rd_le, vecs[i].ele);
            check($sformatf("v%0d_rd", i), rd, vecs[i].erd);
            check($sformatf("v%0d_data", i), data_in, vecs[i].edat);
        end

        // contention for four cycles from reset
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            alu_req = 1; alu_rd = 1; alu_data = 16'hA1A1;
            mem_req = 1; mem_rd = 1; mem_data = 16'hB1B1;
            #1;
`ifdef RR_ARB_EN
            check($sformatf("rr%0d_alu_gnt", c), alu_gnt, (c % 2) == 0);
            check($sformatf("rr%0d_mem_gnt", c), mem_gnt, (c % 2) == 1);
`else
            check($sformatf("fp%0d_alu_gnt", c), alu_gnt, 0);
            check($sformatf("fp%0d_mem_gnt", c), mem_gnt, 1);
`endif
            @(posedge clk);
            #1;
`ifdef RR_ARB_EN
            check($sformatf("arb%0d_data", c), data_in,
                  ((c % 2) == 0) ? 16'hA1A1 : 16'hB1B1);
`else
            check($sformatf("arb%0d_data", c), data_in, 16'hB1B1);
`endif
        end

        // same destination from both sides: served back to back
`ifdef RR_ARB_EN
        exp_first_alu = 1;
        exp_final     = 16'hBBBB;
`else
        exp_first_alu = 0;
        exp_final     = 16'hAAAA;
`endif
        @(negedge clk);
        alu_req = 1; alu_rd = 4; alu_data = 16'hAAAA;
        mem_req = 1; mem_rd = 4; mem_data = 16'hBBBB;
        a_done = 0; m_done = 0; first_seen = 0; first_alu = 0;
        guard = 0;
        while (!(a_done && m_done) && guard < 8) begin
            #1;
            if (alu_gnt && mem_gnt) check("dual_gnt", 1, 0);
            if (!first_seen && (alu_gnt || mem_gnt)) begin
                first_seen = 1;
                first_alu  = alu_gnt;
            end
            if (alu_gnt) a_done = 1;
            if (mem_gnt) m_done = 1;
            @(posedge clk);
            #1;
            if (a_done) alu_req = 0;
            if (m_done) mem_req = 0;
            @(negedge clk);
            guard++;
        end
        check("same_rd_timeout", a_done && m_done, 1);
        check("same_rd_order", first_alu, exp_first_alu);
        check("same_rd_final", data_in, exp_final);
        check("same_rd_addr", rd, 4);
        idle_inputs();

        // reset between grant and write
        @(negedge clk);
        iss_valid = 1; iss_rd = 6;
        @(negedge clk);
        iss_valid = 0;
        mem_req = 1; mem_rd = 1; mem_data = 16'h1111;
        chk_rs1 = 6;
        #1;
        check("mid_hazard_before", hazard, 1);
        @(posedge clk);
        #1;
        check("mid_rd_le_before", rd_le, 1);
        mem_req = 0;
        alu_req = 1; alu_rd = 6; alu_data = 16'h6666;
        #1;
        check("mid_alu_gnt", alu_gnt, 1);
        rst_n = 0;
        #1;
        check("mid_rd_le_rst", rd_le, 0);
        check("mid_rd_rst", rd, 0);
        check("mid_data_rst", data_in, 0);
        check("mid_gnt_rst", alu_gnt, 0);
        check("mid_hazard_rst", hazard, 0);
        @(posedge clk);
        #1;
        check("mid_rd_le_held", rd_le, 0);
        @(negedge clk);
        idle_inputs();
        chk_rs1 = 6;
        rst_n = 1;
        @(posedge clk);
        #1;
        check("mid_no_write_le", rd_le, 0);
        check("mid_no_write_data", data_in, 0);
        check("mid_pend_clear", hazard, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
